// File: rtl/axis_pkg.sv
// Shared constants and lane-offset helper for the AXI-stream broadcast block.
// Latency: none, package only.
// Backpressure: not applicable.
package axis_pkg;

  localparam int unsigned STAT_COUNT_WIDTH = 32;

  // Base bit offset of lane n in a packed multi-lane bus of lanes 'width' wide.
  function automatic int unsigned lane_base(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/axis_broadcast_slot.sv
// One-beat hold register with a per-channel pending mask and the slave ready equation.
// Latency: 1 cycle from load to the held beat appearing on the outputs.
// Backpressure: s_rdy drops while any pending channel holds its ready low; lossless.
module axis_broadcast_slot
  import axis_pkg::*;
#(
  parameter int NUM_CHANNELS = 6,
  parameter int DATA_WIDTH   = 256,
  parameter int USER_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_vld,
  input  logic [DATA_WIDTH-1:0]   load_dat,
  input  logic [USER_WIDTH-1:0]   load_user,
  input  logic                    load_last,
  input  logic [NUM_CHANNELS-1:0] load_mask,
  input  logic [NUM_CHANNELS-1:0] m_rdy,
  output logic                    slot_vld,
  output logic [NUM_CHANNELS-1:0] pending,
  output logic [DATA_WIDTH-1:0]   out_dat,
  output logic [USER_WIDTH-1:0]   out_user,
  output logic                    out_last,
  output logic                    s_rdy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } beat_t;

  beat_t beat_q;

  // The slot is occupied exactly while some channel still owes an accept.
  always_comb begin
    slot_vld = |pending;
    s_rdy    = ~slot_vld | ((pending & ~m_rdy) == '0);
    out_dat  = beat_q.data;
    out_user = beat_q.user;
    out_last = beat_q.last;
  end

  // Load a new beat (overrides same-cycle retires) or retire accepted channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      beat_q  <= '0;
    end else if (load_vld) begin
      pending <= load_mask;
      beat_q  <= '{data: load_dat, user: load_user, last: load_last};
    end else begin
      pending <= pending & ~m_rdy;
    end
  end

endmodule

// File: rtl/axis_broadcast.sv
// Replicates each slave beat to every enabled master; mask latched at packet start. Optional stats: AXIS_BROADCAST_STATS_EN.
// Latency: 1 cycle slave accept to m_axis_tvalid; 1 beat/cycle with all readies high.
// Backpressure: any stalled enabled channel stalls the slave; beats never dropped unless mask is all-zero.
module axis_broadcast
  import axis_pkg::*;
#(
  parameter int NUM_CHANNELS = 6,
  parameter int DATA_WIDTH   = 256,
  parameter int USER_WIDTH   = 1
) (
  input  logic                               s_axis_clk,
  input  logic                               s_axis_rst,
  input  logic [NUM_CHANNELS-1:0]            channel_en,
  output logic [NUM_CHANNELS-1:0]            active_mask,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [USER_WIDTH-1:0]              s_axis_tuser,
  input  logic                               s_axis_tlast,
  output logic [NUM_CHANNELS-1:0]            m_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]            m_axis_tready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_CHANNELS*USER_WIDTH-1:0] m_axis_tuser,
  output logic [NUM_CHANNELS-1:0]            m_axis_tlast
`ifdef AXIS_BROADCAST_STATS_EN
  ,
  input  logic                                     stat_clear,
  output logic [NUM_CHANNELS*STAT_COUNT_WIDTH-1:0] stat_pkt_count
`endif
);

  logic                    in_packet;
  logic                    accept;
  logic                    load_vld;
  logic [NUM_CHANNELS-1:0] mask_sel;
  logic                    slot_vld;
  logic [NUM_CHANNELS-1:0] pending;
  logic [DATA_WIDTH-1:0]   slot_dat;
  logic [USER_WIDTH-1:0]   slot_user;
  logic                    slot_last;

  // Mid-packet beats reuse the latched mask so no channel sees a partial packet.
  // An all-zero mask accepts the beat but never loads the slot.
  always_comb begin
    accept   = s_axis_tvalid & s_axis_tready;
    mask_sel = in_packet ? active_mask : channel_en;
    load_vld = accept & (|mask_sel);
  end

  // Track packet boundaries and latch the enable mask on the first beat of each packet.
  always_ff @(posedge s_axis_clk) begin
    if (s_axis_rst) begin
      in_packet   <= 1'b0;
      active_mask <= '0;
    end else if (accept) begin
      in_packet <= ~s_axis_tlast;
      if (!in_packet) begin
        active_mask <= channel_en;
      end
    end
  end

  axis_broadcast_slot #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DATA_WIDTH   (DATA_WIDTH),
    .USER_WIDTH   (USER_WIDTH)
  ) u_slot (
    .clk       (s_axis_clk),
    .rst       (s_axis_rst),
    .load_vld  (load_vld),
    .load_dat  (s_axis_tdata),
    .load_user (s_axis_tuser),
    .load_last (s_axis_tlast),
    .load_mask (mask_sel),
    .m_rdy     (m_axis_tready),
    .slot_vld  (slot_vld),
    .pending   (pending),
    .out_dat   (slot_dat),
    .out_user  (slot_user),
    .out_last  (slot_last),
    .s_rdy     (s_axis_tready)
  );

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_lane
    assign m_axis_tvalid[n] = slot_vld & pending[n];
    assign m_axis_tdata[lane_base(n, DATA_WIDTH) +: DATA_WIDTH] = slot_dat;
    assign m_axis_tuser[lane_base(n, USER_WIDTH) +: USER_WIDTH] = slot_user;
    assign m_axis_tlast[n]  = slot_last;
  end

`ifdef AXIS_BROADCAST_STATS_EN
  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_stat
    logic [STAT_COUNT_WIDTH-1:0] pkt_cnt;

    // Count packets completed on this channel; clear wins over a same-cycle increment.
    always_ff @(posedge s_axis_clk) begin
      if (s_axis_rst || stat_clear) begin
        pkt_cnt <= '0;
      end else if (m_axis_tvalid[n] && m_axis_tready[n] && m_axis_tlast[n]) begin
        pkt_cnt <= pkt_cnt + STAT_COUNT_WIDTH'(1);
      end
    end

    assign stat_pkt_count[lane_base(n, STAT_COUNT_WIDTH) +: STAT_COUNT_WIDTH] = pkt_cnt;
  end
`endif

endmodule

// File: tb/tb_axis_broadcast.sv
// Directed bench for axis_broadcast with four 8-bit lanes.
// Latency: checks the 1-cycle accept-to-valid path and back-to-back throughput.
// Backpressure: exercises staggered readies, mask boundaries, zero mask and reset.
module tb_axis_broadcast;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int UW = 1;

  logic             s_axis_clk = 1'b0;
  logic             s_axis_rst;
  logic [NC-1:0]    channel_en;
  logic [NC-1:0]    active_mask;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [DW-1:0]    s_axis_tdata;
  logic [UW-1:0]    s_axis_tuser;
  logic             s_axis_tlast;
  logic [NC-1:0]    m_axis_tvalid;
  logic [NC-1:0]    m_axis_tready;
  logic [NC*DW-1:0] m_axis_tdata;
  logic [NC*UW-1:0] m_axis_tuser;
  logic [NC-1:0]    m_axis_tlast;
`ifdef AXIS_BROADCAST_STATS_EN
  logic             stat_clear;
  logic [NC*32-1:0] stat_pkt_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  axis_broadcast #(
    .NUM_CHANNELS (NC),
    .DATA_WIDTH   (DW),
    .USER_WIDTH   (UW)
  ) dut (
    .s_axis_clk    (s_axis_clk),
    .s_axis_rst    (s_axis_rst),
    .channel_en    (channel_en),
    .active_mask   (active_mask),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast)
`ifdef AXIS_BROADCAST_STATS_EN
    ,
    .stat_clear     (stat_clear),
    .stat_pkt_count (stat_pkt_count)
`endif
  );

  always #5 s_axis_clk = ~s_axis_clk;

  function automatic logic [NC*DW-1:0] rep(input logic [DW-1:0] b);
    return {NC{b}};
  endfunction

  task automatic tick();
    @(posedge s_axis_clk);
    #1;
  endtask

  task automatic test_reset();
    s_axis_rst = 1'b1;
    tick();
    tick();
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b0000) $display("FAIL rst_vld: got %b want 0000", m_axis_tvalid); else pass_cnt++;
    total_cnt++;
    if (active_mask !== 4'b0000) $display("FAIL rst_mask: got %b want 0000", active_mask); else pass_cnt++;
    total_cnt++;
    if (m_axis_tdata !== '0 || m_axis_tlast !== '0 || m_axis_tuser !== '0)
      $display("FAIL rst_data: got %h/%b/%b want zeros", m_axis_tdata, m_axis_tlast, m_axis_tuser);
    else pass_cnt++;
    s_axis_rst = 1'b0;
    tick();
    #1;
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL rst_rdy: got %b want 1", s_axis_tready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] b;
    channel_en    = 4'b1111;
    m_axis_tready = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = (i < 8);
      s_axis_tdata  = DW'(i);
      s_axis_tlast  = (i == 7);
      #1;
      if (i < 8) begin
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL b2b_rdy cycle %0d: got %b want 1", i, s_axis_tready); else pass_cnt++;
      end
      total_cnt++;
      if (m_axis_tvalid !== ((i >= 1 && i <= 8) ? 4'b1111 : 4'b0000))
        $display("FAIL b2b_vld cycle %0d: got %b", i, m_axis_tvalid);
      else pass_cnt++;
      if (i >= 1 && i <= 8) begin
        b = DW'(i - 1);
        total_cnt++;
        if (m_axis_tdata !== rep(b)) $display("FAIL b2b_dat cycle %0d: got %h want %h", i, m_axis_tdata, rep(b)); else pass_cnt++;
        total_cnt++;
        if (m_axis_tlast !== ((i == 8) ? 4'b1111 : 4'b0000)) $display("FAIL b2b_last cycle %0d: got %b", i, m_axis_tlast); else pass_cnt++;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_stagger();
    channel_en    = 4'b1111;
    m_axis_tready = 4'b1111;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5; s_axis_tuser = 1'b1; s_axis_tlast = 1'b0;
    #1;
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL stg_rdy0: got %b want 1", s_axis_tready); else pass_cnt++;
    tick();
    s_axis_tdata = 8'h5A; s_axis_tuser = 1'b0; s_axis_tlast = 1'b1;
    m_axis_tready = 4'b1011;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b1111 || m_axis_tdata !== rep(8'hA5) || m_axis_tuser !== 4'b1111)
      $display("FAIL stg_beat: got %b %h %b want 1111 a5a5a5a5 1111", m_axis_tvalid, m_axis_tdata, m_axis_tuser);
    else pass_cnt++;
    total_cnt++;
    if (s_axis_tready !== 1'b0) $display("FAIL stg_rdy1: got %b want 0", s_axis_tready); else pass_cnt++;
    tick();
    for (int c = 2; c < 4; c++) begin
      #1;
      total_cnt++;
      if (m_axis_tvalid !== 4'b0100 || m_axis_tdata !== rep(8'hA5))
        $display("FAIL stg_pend cycle %0d: got %b %h want 0100 a5a5a5a5", c, m_axis_tvalid, m_axis_tdata);
      else pass_cnt++;
      total_cnt++;
      if (s_axis_tready !== 1'b0) $display("FAIL stg_stall cycle %0d: got %b want 0", c, s_axis_tready); else pass_cnt++;
      tick();
    end
    m_axis_tready = 4'b1111;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b0100 || s_axis_tready !== 1'b1)
      $display("FAIL stg_release: got vld %b rdy %b want 0100 1", m_axis_tvalid, s_axis_tready);
    else pass_cnt++;
    tick();
    s_axis_tvalid = 1'b0;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b1111 || m_axis_tdata !== rep(8'h5A) || m_axis_tlast !== 4'b1111 || m_axis_tuser !== 4'b0000)
      $display("FAIL stg_next: got %b %h %b %b want 1111 5a5a5a5a 1111 0000", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b0000) $display("FAIL stg_drain: got %b want 0000", m_axis_tvalid); else pass_cnt++;
    s_axis_tlast = 1'b0;
  endtask

  task automatic test_mask_boundary();
    logic          v   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] d   [7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h00, 8'h00};
    logic          l   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [NC-1:0] en  [7] = '{4'b0011, 4'b0011, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
    logic [NC-1:0] ev  [7] = '{4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1100, 4'b0000};
    logic [DW-1:0] ed  [7] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h00};
    logic [NC-1:0] eam [7] = '{4'b1111, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1100, 4'b1100};
    m_axis_tready = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      s_axis_tvalid = v[c]; s_axis_tdata = d[c]; s_axis_tlast = l[c]; channel_en = en[c];
      #1;
      total_cnt++;
      if (m_axis_tvalid !== ev[c]) $display("FAIL mask_vld cycle %0d: got %b want %b", c, m_axis_tvalid, ev[c]); else pass_cnt++;
      total_cnt++;
      if (active_mask !== eam[c]) $display("FAIL mask_active cycle %0d: got %b want %b", c, active_mask, eam[c]); else pass_cnt++;
      if (ev[c] != 4'b0000) begin
        total_cnt++;
        if (m_axis_tdata !== rep(ed[c])) $display("FAIL mask_dat cycle %0d: got %h want %h", c, m_axis_tdata, rep(ed[c])); else pass_cnt++;
      end
      tick();
    end
    s_axis_tlast = 1'b0;
  endtask

  task automatic test_zero_mask();
    logic          v   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] d   [7] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h40, 8'h00};
    logic          l   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [NC-1:0] en  [7] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 4'b0001};
    logic [NC-1:0] ev  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic [NC-1:0] eam [7] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    m_axis_tready = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      s_axis_tvalid = v[c]; s_axis_tdata = d[c]; s_axis_tlast = l[c]; channel_en = en[c];
      #1;
      if (v[c]) begin
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL zero_rdy cycle %0d: got %b want 1", c, s_axis_tready); else pass_cnt++;
      end
      total_cnt++;
      if (m_axis_tvalid !== ev[c]) $display("FAIL zero_vld cycle %0d: got %b want %b", c, m_axis_tvalid, ev[c]); else pass_cnt++;
      total_cnt++;
      if (active_mask !== eam[c]) $display("FAIL zero_active cycle %0d: got %b want %b", c, active_mask, eam[c]); else pass_cnt++;
      if (c == 6) begin
        total_cnt++;
        if (m_axis_tdata !== rep(8'h40)) $display("FAIL zero_dat: got %h want %h", m_axis_tdata, rep(8'h40)); else pass_cnt++;
      end
      tick();
    end
    s_axis_tlast = 1'b0;
  endtask

  task automatic test_reset_midpacket();
    channel_en    = 4'b1111;
    m_axis_tready = 4'b0000;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h50; s_axis_tlast = 1'b0;
    tick();
    s_axis_tvalid = 1'b0;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b1111 || s_axis_tready !== 1'b0)
      $display("FAIL rmp_stall: got vld %b rdy %b want 1111 0", m_axis_tvalid, s_axis_tready);
    else pass_cnt++;
    s_axis_rst = 1'b1;
    tick();
    s_axis_rst = 1'b0;
    channel_en = 4'b0110;
    m_axis_tready = 4'b1111;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h60; s_axis_tlast = 1'b1;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b0000 || active_mask !== 4'b0000 || m_axis_tdata !== '0)
      $display("FAIL rmp_clear: got vld %b mask %b dat %h want zeros", m_axis_tvalid, active_mask, m_axis_tdata);
    else pass_cnt++;
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL rmp_rdy: got %b want 1", s_axis_tready); else pass_cnt++;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 4'b0110 || active_mask !== 4'b0110 || m_axis_tdata !== rep(8'h60))
      $display("FAIL rmp_fresh: got vld %b mask %b dat %h want 0110 0110 60606060", m_axis_tvalid, active_mask, m_axis_tdata);
    else pass_cnt++;
    tick();
  endtask

`ifdef AXIS_BROADCAST_STATS_EN
  task automatic test_stats();
    logic [31:0] want [NC];
    s_axis_rst = 1'b1;
    tick();
    s_axis_rst = 1'b0;
    channel_en    = 4'b1010;
    m_axis_tready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = DW'(i); s_axis_tlast = (i % 2 == 1);
      tick();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick();
    #1;
    want = '{32'd0, 32'd3, 32'd0, 32'd3};
    for (int n = 0; n < NC; n++) begin
      total_cnt++;
      if (stat_pkt_count[n*32 +: 32] !== want[n])
        $display("FAIL stat_count ch%0d: got %0d want %0d", n, stat_pkt_count[n*32 +: 32], want[n]);
      else pass_cnt++;
    end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h70; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    #1;
    for (int n = 0; n < NC; n++) begin
      total_cnt++;
      if (stat_pkt_count[n*32 +: 32] !== 32'd0)
        $display("FAIL stat_clear ch%0d: got %0d want 0", n, stat_pkt_count[n*32 +: 32]);
      else pass_cnt++;
    end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h71; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick();
    #1;
    want = '{32'd0, 32'd1, 32'd0, 32'd1};
    for (int n = 0; n < NC; n++) begin
      total_cnt++;
      if (stat_pkt_count[n*32 +: 32] !== want[n])
        $display("FAIL stat_after ch%0d: got %0d want %0d", n, stat_pkt_count[n*32 +: 32], want[n]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    s_axis_rst    = 1'b1;
    channel_en    = 4'b1111;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 4'b1111;
`ifdef AXIS_BROADCAST_STATS_EN
    stat_clear    = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_stagger();
    test_mask_boundary();
    test_zero_mask();
    test_reset_midpacket();
`ifdef AXIS_BROADCAST_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axis_broadcast.md
Name: axis_broadcast

Overview:
- Next-generation AXI-stream broadcaster: one slave beat is replicated to NUM_CHANNELS masters and is retired only once every enabled channel has accepted it.
- Adds a runtime channel-enable mask that is applied only at packet boundaries, tlast/tuser passthrough, and full one-beat-per-cycle throughput.
- Sits between a single producer (e.g. sample framer) and parallel consumers (per-channel DSP/DMA), all in one clock domain.

Parameters:
- NUM_CHANNELS, 6, number of master channels (1..32).
- DATA_WIDTH, 256, tdata width per beat.
- USER_WIDTH, 1, tuser width per beat (>=1).

Ports:
- s_axis_clk  in  1  sole clock.
- s_axis_rst  in  1  reset, synchronous, active-high.
- channel_en  in  NUM_CHANNELS  requested channel-enable mask; sampled only at packet start.
- active_mask  out  NUM_CHANNELS  mask in force for the current/last packet.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- s_axis_tuser  in  USER_WIDTH  slave user sideband.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  NUM_CHANNELS  per-channel valid.
- m_axis_tready  in  NUM_CHANNELS  per-channel ready.
- m_axis_tdata  out  NUM_CHANNELS*DATA_WIDTH  packed, channel n at [n*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tuser  out  NUM_CHANNELS*USER_WIDTH  packed likewise.
- m_axis_tlast  out  NUM_CHANNELS  per-channel last.

Behaviour:
- Reset: all m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, active_mask=0, hold slot empty, in_packet=0. s_axis_tready=1 the cycle after reset deasserts.
- Hold slot: one registered beat (data, user, last) plus a pending[NUM_CHANNELS] mask. m_axis_tvalid[n] = slot_valid & pending[n]. All channels see identical data/user/last.
- Per-channel retire: when m_axis_tvalid[n] & m_axis_tready[n], pending[n] clears at the next edge.
- s_axis_tready = ~slot_valid | ((pending & ~m_axis_tready) == 0). Combinational from m_axis_tready, which allows back-to-back beats: with all ready high, throughput is 1 beat/cycle.
- Capture, on s_axis_tvalid & s_axis_tready:
  - Slot loads the beat.
  - mask_sel = in_packet ? active_mask : channel_en.
  - pending <= mask_sel. If in_packet=0, active_mask <= channel_en.
  - in_packet <= ~s_axis_tlast.
  - Latency is 1 cycle, input edge to m_axis_tvalid.
- Mask rules:
  - channel_en changes mid-packet are ignored until the first beat after a tlast beat is captured. No channel ever sees a partial packet.
  - A channel masked off mid-beat still completes the beat already pending.
- All-zero mask: the beat is accepted and discarded. Slot stays empty, no m_axis_tvalid, s_axis_tready stays 1. tlast still updates in_packet.
- AXIS compliance: once m_axis_tvalid[n] is asserted, it and the data stay stable until accepted. No timeout or drop of a started beat.
- Simultaneous events: a retire of the last pending channel and a new capture in the same cycle load the new beat (no bubble). A stalled channel stalls all channels (lossless broadcast).
- Reset mid-packet: the slot and pending clear, in_packet=0, and the next captured beat samples channel_en afresh.

Optional Feature:
- Macro AXIS_BROADCAST_STATS_EN.
- Defined: adds output stat_pkt_count [NUM_CHANNELS*32], packed per channel.
  - Channel n's counter increments when a tlast beat is accepted on channel n; it is 32-bit, wraps at 2^32-1 -> 0.
  - Adds input stat_clear (1 bit, synchronous): zeroes all counters and has priority over an increment in the same cycle. Counters are zeroed by s_axis_rst.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package axis_pkg: STAT_COUNT_WIDTH=32 and the packed-lane index helper (lane n -> base offset).
- One sub-module, axis_broadcast_slot: the hold register, pending-mask update and ready equation for one beat, instantiated once. Replication, mask and in_packet control, and stats stay in the top module.

Test Plan:
- N=4, channel_en=4'b1111, all ready=1, 8 beats 0..7 back-to-back -> each channel receives 0..7 one per cycle, s_axis_tready never drops, first m_axis_tvalid 1 cycle after the first input.
- Ready staggering: ch2 ready low 3 cycles on beat 0xA5 -> ch0/1/3 accept in cycle 1, pending=4'b0100, s_axis_tready=0 for 3 cycles, ch2 accepts 0xA5 and the next beat follows with no bubble.
- Mask at boundary: 4-beat packet under mask 4'b0011, switch channel_en to 4'b1100 after beat 1 -> beats 2,3 go only to ch0/1 and active_mask stays 0011; the next packet goes to ch2/3 and active_mask=1100.
- channel_en=0: 5-beat packet -> s_axis_tready=1 throughout, no m_axis_tvalid, in_packet returns to 0 after tlast.
- Reset asserted with a stalled beat pending -> all m_axis_tvalid=0 next cycle, active_mask=0, and the next packet uses current channel_en.
- STATS_EN: 3 packets to mask 4'b1010 -> stat_pkt_count ch1=ch3=3, ch0=ch2=0. stat_clear coinciding with a tlast accept -> that counter reads 0.
